// File: rtl/key_event_tracker.sv
// key_event_tracker
// Turns successive 6-slot HID boot-protocol keycode reports into per-key
// release/press events. Each accepted report is compared with the last
// committed report. The tracker emits releases first, then presses, one
// slot per cycle, and stalls while the single-entry event register is full.
// Optional build macro KEY_EVENT_COUNT_EN adds output held_count: the
// number of distinct keys held in the committed report.
module key_event_tracker #(
  parameter int         SLOTS         = 6,
  parameter logic [7:0] ROLLOVER_CODE = 8'h01
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               report_valid,
  output logic               report_ready,
  input  logic [8*SLOTS-1:0] report_keycodes,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [7:0]         event_keycode,
  output logic               event_press
`ifdef KEY_EVENT_COUNT_EN
  ,
  output logic [3:0]         held_count
`endif
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int RW = 8 * SLOTS;

  typedef enum logic [1:0] {IDLE, SCAN_REL, SCAN_PRS, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] new_q, new_d;
  logic [RW-1:0] prev_q, prev_d;
  logic          ev_valid_q, ev_valid_d;
  logic [7:0]    ev_kc_q, ev_kc_d;
  logic          ev_press_q, ev_press_d;

  logic [SLOTS-1:0] roll_hit;
  logic [SLOTS-1:0] rel_hit;
  logic [SLOTS-1:0] prs_hit;
`ifdef KEY_EVENT_COUNT_EN
  logic [SLOTS-1:0] new_first;
`endif

  logic       ev_free;
  logic       last_slot;
  logic       cur_hit;
  logic [7:0] cur_kc;

  // Per-slot comparison network. A slot qualifies for an event when:
  //   - its key is nonzero,
  //   - its key is absent from the other report,
  //   - it is the first occurrence of that key within its own report.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    logic [7:0] prev_kc;
    logic [7:0] new_kc;
    logic       prev_in_new;
    logic       new_in_prev;
    logic       prev_dup;
    logic       new_dup;

    assign prev_kc      = prev_q[8*gi +: 8];
    assign new_kc       = new_q[8*gi +: 8];
    assign roll_hit[gi] = (report_keycodes[8*gi +: 8] == ROLLOVER_CODE);

    // Membership in the other report and in earlier slots of the same report.
    always_comb begin
      prev_in_new = 1'b0;
      new_in_prev = 1'b0;
      prev_dup    = 1'b0;
      new_dup     = 1'b0;
      for (int j = 0; j < SLOTS; j++) begin
        if (new_q[8*j +: 8] == prev_kc) prev_in_new = 1'b1;
        if (prev_q[8*j +: 8] == new_kc) new_in_prev = 1'b1;
        if (j < gi) begin
          if (prev_q[8*j +: 8] == prev_kc) prev_dup = 1'b1;
          if (new_q[8*j +: 8] == new_kc)   new_dup  = 1'b1;
        end
      end
    end

    assign rel_hit[gi] = (prev_kc != 8'h00) && !prev_in_new && !prev_dup;
    assign prs_hit[gi] = (new_kc != 8'h00) && !new_in_prev && !new_dup;
`ifdef KEY_EVENT_COUNT_EN
    assign new_first[gi] = (new_kc != 8'h00) && !new_dup;
`endif
  end

  // A slot may be evaluated only when its potential event has somewhere to go.
  assign ev_free   = !ev_valid_q || event_ready;
  assign last_slot = (idx_q == IW'(SLOTS - 1));

  // Select the slot under evaluation from the report being scanned.
  always_comb begin
    cur_kc  = 8'h00;
    cur_hit = 1'b0;
    if (state_q == SCAN_PRS) begin
      cur_kc  = new_q[int'(idx_q)*8 +: 8];
      cur_hit = prs_hit[idx_q];
    end else if (state_q == SCAN_REL) begin
      cur_kc  = prev_q[int'(idx_q)*8 +: 8];
      cur_hit = rel_hit[idx_q];
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic, scan index, report latches and event register loading.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    new_d      = new_q;
    prev_d     = prev_q;
    ev_valid_d = ev_valid_q && !event_ready;
    ev_kc_d    = ev_kc_q;
    ev_press_d = ev_press_q;
    case (state_q)
      IDLE: begin
        // Reports carrying ErrorRollOver are consumed but ignored.
        if (report_valid && !(|roll_hit)) begin
          new_d   = report_keycodes;
          idx_d   = '0;
          state_d = SCAN_REL;
        end
      end
      SCAN_REL, SCAN_PRS: begin
        if (ev_free) begin
          if (cur_hit) begin
            ev_valid_d = 1'b1;
            ev_kc_d    = cur_kc;
            ev_press_d = (state_q == SCAN_PRS);
          end
          if (last_slot) begin
            idx_d   = '0;
            state_d = (state_q == SCAN_REL) ? SCAN_PRS : COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        prev_d  = new_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; reset clears the committed report as well.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q      <= '0;
      new_q      <= '0;
      prev_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_kc_q    <= 8'h00;
      ev_press_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      new_q      <= new_d;
      prev_q     <= prev_d;
      ev_valid_q <= ev_valid_d;
      ev_kc_q    <= ev_kc_d;
      ev_press_q <= ev_press_d;
    end
  end

  // Ready is a pure state decode, held low while reset is applied.
  assign report_ready  = (state_q == IDLE) && !Reset;
  assign event_valid   = ev_valid_q;
  assign event_keycode = ev_kc_q;
  assign event_press   = ev_press_q;

`ifdef KEY_EVENT_COUNT_EN
  logic [3:0] held_q, held_d;

  // Distinct held keys are recounted from the report being committed.
  always_comb begin
    held_d = held_q;
    if (state_q == COMMIT) begin
      held_d = 4'd0;
      for (int j = 0; j < SLOTS; j++) begin
        held_d = held_d + {3'b000, new_first[j]};
      end
    end
  end

  // Held-key counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) held_q <= 4'd0;
    else       held_q <= held_d;
  end

  assign held_count = held_q;
`endif

endmodule

// File: tb/tb_key_event_tracker.sv
// Bench for key_event_tracker: table of reports with their expected event
// lists feeding a scoreboard queue, plus hand-written stall and reset cases.
module tb_key_event_tracker;
  localparam int SLOTS = 6;

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic               report_valid = 1'b0;
  logic               report_ready;
  logic [8*SLOTS-1:0] report_keycodes = '0;
  logic               event_valid;
  logic               event_ready = 1'b1;
  logic [7:0]         event_keycode;
  logic               event_press;
`ifdef KEY_EVENT_COUNT_EN
  logic [3:0]         held_count;
`endif

  always #5 Clk = ~Clk;

  key_event_tracker #(.SLOTS(SLOTS), .ROLLOVER_CODE(8'h01)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .report_valid    (report_valid),
    .report_ready    (report_ready),
    .report_keycodes (report_keycodes),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_keycode   (event_keycode),
    .event_press     (event_press)
`ifdef KEY_EVENT_COUNT_EN
    ,
    .held_count      (held_count)
`endif
  );

  typedef struct {
    logic [47:0] rpt;
    int          n_ev;
    logic [26:0] evs;    // up to three {press,keycode} events, first in [8:0]
    int          held;
    bit          measure;
    bit          roll;
  } vec_t;

  vec_t       vecs[14];
  logic [8:0] sb_q[$];
  logic [8:0] mon_exp;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [47:0] mk(input logic [7:0] s0, s1, s2, s3, s4, s5);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  function automatic logic [8:0] pr(input logic [7:0] k);
    return {1'b1, k};
  endfunction

  function automatic logic [8:0] rl(input logic [7:0] k);
    return {1'b0, k};
  endfunction

  function automatic vec_t mkv(input logic [47:0] r, input int n,
                               input logic [8:0] e0, e1, e2,
                               input int held, input bit meas, input bit roll);
    vec_t v;
    v.rpt = r; v.n_ev = n; v.evs = {e2, e1, e0};
    v.held = held; v.measure = meas; v.roll = roll;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every completed event handshake is popped and compared.
  always @(negedge Clk) begin
    if (!Reset && event_valid && event_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got kc=%02h press=%0b expected none",
                 event_keycode, event_press);
      end else begin
        mon_exp = sb_q.pop_front();
        $display("event kc=%02h press=%0b", event_keycode, event_press);
        if ({event_press, event_keycode} !== mon_exp) begin
          errors++;
          $display("FAIL event got kc=%02h press=%0b expected kc=%02h press=%0b",
                   event_keycode, event_press, mon_exp[7:0], mon_exp[8]);
        end
      end
    end
  end

  // Offer one report, wait for acceptance, optionally check accept-to-accept period.
  task automatic send(input logic [47:0] r, input bit measure, input bit roll);
    int cnt;
    @(posedge Clk); #1;
    report_valid    = 1'b1;
    report_keycodes = r;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (report_ready) break;
    end
    chk("accept_ready", report_ready, 1);
    @(posedge Clk); #1;
    report_valid = 1'b0;
    if (roll) begin
      @(negedge Clk);
      chk("rollover_ready", report_ready, 1);
    end
    if (measure) begin
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge Clk);
        cnt++;
        if (report_ready) break;
      end
      chk("accept_period", cnt, 2*SLOTS + 2);
    end
  endtask

  // Wait until the tracker is idle with all expected events delivered.
  task automatic wait_idle();
    for (int k = 0; k < 500; k++) begin
      @(negedge Clk);
      if (report_ready && !event_valid && sb_q.size() == 0) break;
    end
    chk("drain", sb_q.size(), 0);
    chk("idle_ready", report_ready, 1);
  endtask

  task automatic chk_held(input int exp);
`ifdef KEY_EVENT_COUNT_EN
    chk("held_count", held_count, exp);
`else
    if (exp < 0) $display("held_count unused");
`endif
  endtask

  initial begin
    vecs[0]  = mkv(mk(8'h04,0,0,0,0,0), 1, pr(8'h04), 0, 0, 1, 1, 0);
    vecs[1]  = mkv(mk(8'h04,8'h16,0,0,0,0), 1, pr(8'h16), 0, 0, 2, 0, 0);
    vecs[2]  = mkv(mk(0,0,0,0,0,0), 2, rl(8'h04), rl(8'h16), 0, 0, 0, 0);
    vecs[3]  = mkv(mk(8'h04,8'h16,0,0,0,0), 2, pr(8'h04), pr(8'h16), 0, 2, 0, 0);
    vecs[4]  = mkv(mk(8'h01,8'h01,8'h01,8'h01,8'h01,8'h01), 0, 0, 0, 0, 2, 0, 1);
    vecs[5]  = mkv(mk(8'h04,8'h16,0,0,0,0), 0, 0, 0, 0, 2, 0, 0);
    vecs[6]  = mkv(mk(8'h16,8'h04,8'h05,0,0,0), 1, pr(8'h05), 0, 0, 3, 0, 0);
    vecs[7]  = mkv(mk(0,0,8'h05,0,0,8'h09), 3, rl(8'h16), rl(8'h04), pr(8'h09), 2, 0, 0);
    vecs[8]  = mkv(mk(0,0,0,0,0,0), 2, rl(8'h05), rl(8'h09), 0, 0, 0, 0);
    vecs[9]  = mkv(mk(8'h07,8'h07,0,0,0,0), 1, pr(8'h07), 0, 0, 1, 0, 0);
    vecs[10] = mkv(mk(0,0,0,0,0,0), 1, rl(8'h07), 0, 0, 0, 0, 0);
    vecs[11] = mkv(mk(8'h04,8'h01,0,0,0,0), 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mkv(mk(0,0,0,0,0,8'h2A), 1, pr(8'h2A), 0, 0, 1, 1, 0);
    vecs[13] = mkv(mk(0,0,0,0,0,0), 1, rl(8'h2A), 0, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_ready", report_ready, 0);
    chk("reset_event", {event_valid, event_press, event_keycode}, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_reset_ready", report_ready, 1);
    chk_held(0);

    // Table-driven reports.
    for (int v = 0; v < 14; v++) begin
      $display("report %0d slots=%h", v, vecs[v].rpt);
      for (int e = 0; e < vecs[v].n_ev; e++) sb_q.push_back(vecs[v].evs[9*e +: 9]);
      send(vecs[v].rpt, vecs[v].measure, vecs[v].roll);
      wait_idle();
      chk_held(vecs[v].held);
    end

    // Consumer stall during a three-press report.
    $display("report stall slots=%h", mk(8'h04,8'h05,8'h06,0,0,0));
    @(posedge Clk); #1;
    event_ready = 1'b0;
    sb_q.push_back(pr(8'h04)); sb_q.push_back(pr(8'h05)); sb_q.push_back(pr(8'h06));
    send(mk(8'h04,8'h05,8'h06,0,0,0), 0, 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (event_valid) break;
    end
    chk("stall_first_valid", event_valid, 1);
    for (int s = 0; s < 5; s++) begin
      @(negedge Clk);
      chk("stall_hold", {event_valid, event_press, event_keycode}, {1'b1, 1'b1, 8'h04});
      chk("stall_busy", report_ready, 0);
    end
    @(posedge Clk); #1;
    event_ready = 1'b1;
    wait_idle();
    chk_held(3);

    $display("report release_all slots=%h", 48'h0);
    sb_q.push_back(rl(8'h04)); sb_q.push_back(rl(8'h05)); sb_q.push_back(rl(8'h06));
    send(48'h0, 0, 0);
    wait_idle();
    chk_held(0);

    // Reset during the press scan abandons the report.
    $display("report reset_mid_scan slots=%h", mk(8'h0A,8'h0B,8'h0C,0,0,0));
    @(posedge Clk); #1;
    event_ready = 1'b0;
    send(mk(8'h0A,8'h0B,8'h0C,0,0,0), 0, 0);
    repeat (8) @(posedge Clk);
    #1;
    chk("pre_reset_event", {event_valid, event_press, event_keycode}, {1'b1, 1'b1, 8'h0A});
    Reset = 1'b1;
    #1;
    chk("mid_reset_outputs",
        {report_ready, event_valid, event_press, event_keycode}, 0);
    chk_held(0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("after_reset_ready", report_ready, 1);
    chk("after_reset_valid", event_valid, 0);
    event_ready = 1'b1;
    sb_q.push_back(pr(8'h0A)); sb_q.push_back(pr(8'h0B)); sb_q.push_back(pr(8'h0C));
    send(mk(8'h0A,8'h0B,8'h0C,0,0,0), 1, 0);
    wait_idle();
    chk_held(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_tracker.md
Name: key_event_tracker

Overview:
- Sits between the USB HID keyboard report path and the keycode-to-note mapper.
- Accepts 6-slot boot-protocol keycode reports and compares each against the last committed report.
- Emits one event per key change: release events first, then press events.
- Downstream note logic sees clean per-key press/release events instead of full report snapshots.

Parameters:
SLOTS, 6, keycode slots per report (slot i = report_keycodes[8i+7:8i])
ROLLOVER_CODE, 8'h01, HID ErrorRollOver keycode; a report containing it is discarded

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
report_valid  in  1  new report offered
report_ready  out  1  tracker can accept a report
report_keycodes  in  8*SLOTS  slot keycodes, 0 = empty slot
event_valid  out  1  event register holds an event
event_ready  in  1  consumer takes the event
event_keycode  out  8  keycode of the event
event_press  out  1  1 = press, 0 = release

Behaviour:
- Reset: all outputs 0 except report_ready=0 while Reset is high and 1 in the first cycle after. prev_report is cleared to all zeros. FSM goes to IDLE. Reset mid-scan abandons the scan with no partial commit.
- FSM states: IDLE, SCAN_REL, SCAN_PRS, COMMIT.
- IDLE:
  - report_ready=1.
  - A report transfers when report_valid && report_ready. It is latched into new_report, slot index i is set to 0, and the FSM moves to SCAN_REL.
  - If the accepted report has any slot == ROLLOVER_CODE, it is discarded: the FSM stays in IDLE, emits no events, and prev_report is unchanged.
- report_ready=0 in every state except IDLE.
- SCAN_REL: each cycle, evaluate prev slot i, but only when the event register is free (event_valid==0, or event_ready==1 this cycle). Otherwise hold i.
  - A release event is emitted when prev[i]!=0, prev[i] is absent from all new slots, and prev[i] is absent from prev slots 0..i-1 (de-duplication).
  - Emitting means loading event_keycode/event_press and setting event_valid on the next edge.
  - When i==SLOTS-1 has been evaluated, set i=0 and go to SCAN_PRS.
- SCAN_PRS: same stall rule. A press event is emitted when new[i]!=0, new[i] is absent from all prev slots, and new[i] is absent from new slots 0..i-1. After the last slot, go to COMMIT.
- COMMIT: one cycle. prev_report <= new_report, then go to IDLE.
- Throughput: one slot per cycle with no stall. Unstalled, an accepted report returns to report_ready=1 exactly 2*SLOTS+2 cycles after the accept edge (14 for SLOTS=6).
- Event handshake:
  - event_valid stays high with stable keycode/press until event_ready is sampled high.
  - event_valid clears on that edge unless a new event is loaded in the same cycle, so back-to-back events are allowed.
  - The final event may still be pending in IDLE. A new report may be accepted then; scanning resumes under the normal stall rule.
- Boundaries:
  - Identical report: 0 events.
  - All-zero report after keys held: releases only.
  - Event-free slots cost one cycle each.
- Purely combinational paths: none from inputs to outputs except the report_ready state decode.

Optional Feature:
- Macro: KEY_EVENT_COUNT_EN.
- Defined: adds output held_count[3:0], the number of distinct nonzero keycodes in prev_report. It updates on the COMMIT edge, resets to 0, and is unchanged by discarded rollover reports.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
1. After reset, send report slots {04,00,00,00,00,00}, event_ready=1 → exactly one event {kc=04, press=1}; report_ready high again 14 cycles after accept.
2. Then {04,16,00,00,00,00} → one event {16, press}. Then all-zero → {04, release} followed by {16, release}, in that order, with no presses.
3. With {04,16,...} committed, send {01,01,01,01,01,01} → no events and report_ready stays 1. Next report {04,16,...} → 0 events.
4. Hold event_ready=0 for 5 cycles during a 3-press report {04,05,06,...} → event_valid and keycode 04 stable for all 5 cycles, FSM index frozen. On release, the sequence 04,05,06 follows with no loss or duplicate.
5. Duplicate report {07,07,00,00,00,00} from empty → single {07, press}. Then all-zero → single {07, release}. With KEY_EVENT_COUNT_EN, held_count goes 1 then 0.
6. Assert Reset mid-SCAN_PRS → all outputs 0, no commit. Re-send the same report → full press set re-emitted.
